// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle MIPS multiply/divide unit holding the HI/LO registers.
//   One operation at a time: 1 capture edge, WIDTH iteration edges, 1 fix edge.
//   Multiply is shift-add on operand magnitudes; divide is restoring, one
//   quotient bit per iteration. Signs are applied in the FIX state.
//
// Ports
//   i_clk      clock, all state changes on rising edge
//   i_reset    synchronous active-high reset
//   i_start    begin operation (accepted only in IDLE)
//   i_op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_rs_data  operand A (multiplicand / dividend), also MTHI/MTLO data
//   i_rt_data  operand B (multiplier / divisor)
//   i_mthi     write i_rs_data into HI (IDLE, no start)
//   i_mtlo     write i_rs_data into LO (IDLE, no start)
//   o_hi       HI register (product high / remainder)
//   o_lo       LO register (product low / quotient)
//   o_busy     operation in progress (RUN or FIX)
//   o_done     one-cycle pulse when HI/LO take a new result
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // state  | meaning
    // S_IDLE | waiting; accepts start or MTHI/MTLO
    // S_RUN  | one multiply/divide iteration per edge
    // S_FIX  | sign correction, HI/LO write, done pulse
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_start_acc;
    logic   w_mt_ok;
    logic   w_busy;

    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_rs_raw;
    logic               r_is_div;
    logic               r_neg_main;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_start_acc = 1'b0;
        w_mt_ok     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_start_acc = 1'b1;
                end else begin
                    w_mt_ok = 1'b1;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- operand capture ----------------
    // Signed ops are MULT (00) and DIV (10), i.e. op[0] == 0.
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = ~i_op[0];
    assign w_a_neg  = w_signed & i_rs_data[WIDTH-1];
    assign w_b_neg  = w_signed & i_rt_data[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_rs_data : i_rs_data;
    assign w_b_mag  = w_b_neg ? -i_rt_data : i_rt_data;

    // ---------------- iteration datapath ----------------
    // Multiply: r_acc = {partial sum, remaining multiplier bits}, shifting right.
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

    // Divide: r_acc = {partial remainder, dividend/quotient}, shifting left.
    // The remainder stays below the divisor, so WIDTH+1 bits hold the trial.
    logic [WIDTH:0] w_div_shift;
    logic [WIDTH:0] w_div_diff;
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_rs_raw   <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div0     <= 1'b0;
        end else if (w_start_acc) begin
            r_cnt      <= '0;
            r_is_div   <= i_op[1];
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div0     <= i_op[1] & (i_rt_data == '0);
            r_rs_raw   <= i_rs_data;
            if (i_op[1]) begin
                r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                r_opnd <= w_b_mag;
            end else begin
                r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                r_opnd <= w_a_mag;
            end
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                if (!w_div_diff[WIDTH]) begin
                    r_acc <= {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
        end
    end

    // ---------------- sign fix and HI/LO ----------------
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = r_neg_main ? -r_acc : r_acc;
    assign w_quo  = r_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem  ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_FIX) begin
                r_done <= 1'b1;
                if (!r_is_div) begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end else if (r_div0) begin
                    r_hi <= r_rs_raw;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end else if (w_mt_ok) begin
                if (i_mthi) begin
                    r_hi <= i_rs_data;
                end
                if (i_mtlo) begin
                    r_lo <= i_rs_data;
                end
            end
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = w_busy;
    assign o_done = r_done;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle MIPS multiply/divide unit sitting directly downstream of the register file. It consumes the two register read ports (rs, rt) for MULT/MULTU/DIV/DIVU and holds the HI/LO result registers. The writeback path reads HI/LO for MFHI/MFLO, and MTHI/MTLO write them directly. One operation runs at a time, 33 cycles each, using a shift-add multiplier and a restoring divider.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count = WIDTH; counter width = clog2(WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
rs_data  input  WIDTH  operand A (multiplicand / dividend), from regfile read port 0
rt_data  input  WIDTH  operand B (multiplier / divisor), from regfile read port 1
mthi  input  1  write rs_data into HI
mtlo  input  1  write rs_data into LO
hi  output  WIDTH  HI register (product high / remainder)
lo  output  WIDTH  LO register (product low / quotient)
busy  output  1  high in RUN or FIX state (combinational from state)
done  output  1  registered, one-cycle pulse when HI/LO take a new result

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0. Reset mid-operation aborts the operation; no HI/LO update occurs.
- States:
  - IDLE: on start=1 at edge E0, capture op, operand magnitudes (absolute value for signed ops), result signs and a divide-by-zero flag; counter<=0; go to RUN.
  - RUN: one iteration per edge; counter increments each edge; on the edge where counter==WIDTH-1, go to FIX. RUN therefore lasts 32 edges (E1..E32).
  - FIX: at E33, apply sign correction, write hi/lo, set done<=1, go to IDLE.
- Latency: result and done are visible in the cycle after E33 (33 cycles after the start edge). done clears on the next edge. The next start is accepted in that same cycle.
- Operands are captured at E0. Later changes on rs_data/rt_data have no effect.
- Multiply: 2*WIDTH-bit accumulate. Unsigned for MULTU. For MULT, compute the product of magnitudes and two's-complement negate the full 64 bits if the operand signs differ. hi=product[63:32], lo=product[31:0].
- Divide: restoring, one quotient bit per iteration.
  - DIVU is unsigned.
  - DIV operates on magnitudes, then: quotient is negated if operand signs differ; remainder takes the dividend's sign (truncating division).
  - lo=quotient, hi=remainder.
- Divide by zero (rt_data==0 at E0, DIV or DIVU): still 33 cycles; lo=32'hFFFFFFFF, hi=captured rs_data.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
- start while busy: ignored, no effect on the running operation.
- mthi/mtlo, in IDLE with start=0: hi/lo<=rs_data at that edge. Both may be asserted together; both registers are written.
- mthi/mtlo while busy: ignored.
- start and mthi/mtlo in the same IDLE cycle: start wins; mt writes are dropped.
- done is never asserted by mthi/mtlo.

Test Plan:
- After reset, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy=1 for 33 cycles; done pulse 33 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100, done at the same latency.
- Start DIVU 50/5, then in cycle 5 pulse start (MULT 2x2) and mthi with rs_data=0xDEAD, and change rs_data -> all ignored; final hi=0, lo=10. Next cycle mtlo with rs_data=0x1234 -> lo=0x1234, done stays 0.
- Start MULTU 3x3, assert reset at cycle 10 -> busy=0, hi=lo=0, no done pulse. A fresh MULTU 3x3 afterwards -> lo=9.
